thermostat_fsm: RTL and testbench

//  Parametrised thermostat controller and successor to the single-compare heat/cool block.

---
 rtl/thermostat_fsm.sv | 120 ++++++++++++
 tb/tb_thermostat_fsm.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/thermostat_fsm.sv
// thermostat_fsm: heat/cool controller with a hysteresis band around the
// setpoint, a minimum on-time once heating or cooling starts, a lockout
// after either output drops, and an enable input that forces the outputs off.
// The outputs are registered and follow the FSM state one cycle after the
// inputs are sampled.
module thermostat_fsm #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned HYST    = 2,
  parameter int unsigned MIN_ON  = 16,
  parameter int unsigned MIN_OFF = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [WIDTH-1:0] current_temp,
  input  logic [WIDTH-1:0] set_temp,
  output logic             heat,
  output logic             cool,
  output logic [1:0]       state
);

  // The dwell counter must reach the larger of the two timing limits.
  localparam int unsigned CNT_LIMIT = (MIN_ON > MIN_OFF) ? MIN_ON : MIN_OFF;
  localparam int unsigned CW        = $clog2(CNT_LIMIT + 1);

  localparam logic [CW-1:0] CNT_MAX  = '1;
  localparam logic [CW-1:0] ON_LAST  = CW'(MIN_ON - 1);
  localparam logic [CW-1:0] OFF_LAST = CW'(MIN_OFF - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_HEAT    = 2'd1,
    S_COOL    = 2'd2,
    S_LOCKOUT = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            heat_q, cool_q;

  logic [WIDTH:0]   hi_sum;
  logic [WIDTH:0]   lo_diff;
  logic [WIDTH-1:0] hi_thr;
  logic [WIDTH-1:0] lo_thr;

  // Thresholds are built one bit wider than the temperature so the carry or
  // borrow out can be used to saturate at the ends of the range.
  always_comb begin
    hi_sum  = {1'b0, set_temp} + (WIDTH+1)'(HYST);
    lo_diff = {1'b0, set_temp} - (WIDTH+1)'(HYST);
    hi_thr  = hi_sum[WIDTH]  ? {WIDTH{1'b1}} : hi_sum[WIDTH-1:0];
    lo_thr  = lo_diff[WIDTH] ? {WIDTH{1'b0}} : lo_diff[WIDTH-1:0];
  end

  // Next-state selection; the dwell counter restarts on any state change.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (enable && (current_temp < lo_thr)) begin
          state_d = S_HEAT;
        end else if (enable && (current_temp > hi_thr)) begin
          state_d = S_COOL;
        end
      end
      S_HEAT: begin
        // Losing enable overrides the minimum on-time.
        if (!enable) begin
          state_d = S_LOCKOUT;
        end else if ((current_temp >= set_temp) && (cnt_q >= ON_LAST)) begin
          state_d = S_LOCKOUT;
        end
      end
      S_COOL: begin
        if (!enable) begin
          state_d = S_LOCKOUT;
        end else if ((current_temp <= set_temp) && (cnt_q >= ON_LAST)) begin
          state_d = S_LOCKOUT;
        end
      end
      S_LOCKOUT: begin
        // Enable and temperature are deliberately ignored while locked out.
        if (cnt_q == OFF_LAST) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Dwell counter: zero on entry to a state, then count up and saturate.
  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // State, counter and decoded drive outputs; reset kills the drives at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      heat_q  <= 1'b0;
      cool_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      heat_q  <= (state_d == S_HEAT);
      cool_q  <= (state_d == S_COOL);
    end
  end

  assign heat  = heat_q;
  assign cool  = cool_q;
  assign state = state_q;

endmodule

// File: tb/tb_thermostat_fsm.sv
// tb_thermostat_fsm: directed vector table for hysteresis, minimum on-time,
// lockout, enable override, saturation and setpoint changes, plus a
// hand-written asynchronous reset sequence.
module tb_thermostat_fsm;

  logic       clk;
  logic       rst_n;
  logic       enable;
  logic [7:0] current_temp;
  logic [7:0] set_temp;
  logic       heat;
  logic       cool;
  logic [1:0] state;

  int n_tests = 0;
  int n_fail  = 0;

  thermostat_fsm dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .current_temp (current_temp),
    .set_temp     (set_temp),
    .heat         (heat),
    .cool         (cool),
    .state        (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       en;
    logic [7:0] cur;
    logic [7:0] set;
    int         reps;
    logic [1:0] exp_state;
  } vec_t;

  vec_t vecs[32];
  int   n_vec = 0;

  task automatic add(input logic en, input logic [7:0] cur, input logic [7:0] set,
                     input int reps, input logic [1:0] es);
    vecs[n_vec].en        = en;
    vecs[n_vec].cur       = cur;
    vecs[n_vec].set       = set;
    vecs[n_vec].reps      = reps;
    vecs[n_vec].exp_state = es;
    n_vec++;
  endtask

  task automatic chk(input string tag, input int id, input logic [1:0] es);
    logic eh, ec;
    eh = (es == 2'd1);
    ec = (es == 2'd2);
    n_tests += 3;
    if (state !== es) begin
      n_fail++;
      $display("FAIL %s[%0d] state: got %0d want %0d", tag, id, state, es);
    end
    if (heat !== eh) begin
      n_fail++;
      $display("FAIL %s[%0d] heat: got %b want %b", tag, id, heat, eh);
    end
    if (cool !== ec) begin
      n_fail++;
      $display("FAIL %s[%0d] cool: got %b want %b", tag, id, cool, ec);
    end
    $display("[TB] %s[%0d] en=%b cur=%0d set=%0d -> state=%0d heat=%b cool=%b",
             tag, id, enable, current_temp, set_temp, state, heat, cool);
  endtask

  task automatic step(input logic en, input logic [7:0] cur, input logic [7:0] set);
    enable       = en;
    current_temp = cur;
    set_temp     = set;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Hysteresis entry (heat side), minimum on-time with early target, lockout.
    add(1'b1,  8'd98, 8'd100,  2, 2'd0);
    add(1'b1,  8'd97, 8'd100,  1, 2'd1);
    add(1'b1,  8'd97, 8'd100,  2, 2'd1);
    add(1'b1, 8'd100, 8'd100, 13, 2'd1);
    add(1'b1, 8'd100, 8'd100,  8, 2'd3);
    add(1'b1, 8'd100, 8'd100,  1, 2'd0);
    // Mirror on the cool side, then enable override at cnt=3.
    add(1'b1, 8'd102, 8'd100,  2, 2'd0);
    add(1'b1, 8'd103, 8'd100,  1, 2'd2);
    add(1'b1, 8'd103, 8'd100,  3, 2'd2);
    add(1'b0, 8'd103, 8'd100,  1, 2'd3);
    add(1'b0, 8'd150, 8'd100,  7, 2'd3);
    add(1'b0, 8'd150, 8'd100,  6, 2'd0);
    // Saturated thresholds at both ends of the range.
    add(1'b1, 8'd255, 8'd254,  3, 2'd0);
    add(1'b1,   8'd0,   8'd1,  3, 2'd0);
    // Setpoint dropped below temperature mid-HEAT: lockout, idle, then cool.
    add(1'b1,  8'd90, 8'd100,  1, 2'd1);
    add(1'b1,  8'd90, 8'd100, 20, 2'd1);
    add(1'b1,  8'd90,  8'd80,  1, 2'd3);
    add(1'b1,  8'd90,  8'd80,  7, 2'd3);
    add(1'b1,  8'd90,  8'd80,  1, 2'd0);
    add(1'b1,  8'd90,  8'd80,  1, 2'd2);

    rst_n        = 1'b0;
    enable       = 1'b1;
    current_temp = 8'd100;
    set_temp     = 8'd100;
    #12;
    chk("reset", 0, 2'd0);
    rst_n = 1'b1;

    for (int v = 0; v < n_vec; v++) begin
      for (int r = 0; r < vecs[v].reps; r++) begin
        step(vecs[v].en, vecs[v].cur, vecs[v].set);
        chk("vec", v, vecs[v].exp_state);
      end
    end

    // Asynchronous reset in the middle of a HEAT dwell.
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    step(1'b1, 8'd97, 8'd100);
    chk("arst_enter", 0, 2'd1);
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 8'd97, 8'd100);
      chk("arst_hold", k, 2'd1);
    end
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_now", 0, 2'd0);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("arst_rel", 0, 2'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
